// File: rtl/data_cache_pkg.sv
// rtl/data_cache_pkg.sv - shared geometry defaults and FSM state encoding for data_cache
// Optional statistics counters are enabled by defining DCACHE_STAT_EN.
package data_cache_pkg;

  localparam int DEF_WORD_SEL_WIDTH = 2;
  localparam int DEF_INDEX_WIDTH    = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WB     = 2'd1,
    ST_REFILL = 2'd2
  } state_e;

endpackage

// File: rtl/data_cache_array.sv
// rtl/data_cache_array.sv - tag/valid/dirty/data storage with async read and sync write
// All ports address the same line; the core holds cpu_addr stable for the whole miss.
module data_cache_array import data_cache_pkg::*; #(
  parameter int WORD_SEL_WIDTH = DEF_WORD_SEL_WIDTH,
  parameter int INDEX_WIDTH    = DEF_INDEX_WIDTH,
  parameter int TAG_WIDTH      = 32 - 2 - WORD_SEL_WIDTH - INDEX_WIDTH
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [INDEX_WIDTH-1:0]                 index_i,
  output logic                                   valid_o,
  output logic                                   dirty_o,
  output logic [TAG_WIDTH-1:0]                   tag_o,
  output logic [(1<<WORD_SEL_WIDTH)-1:0][31:0]   line_o,
  input  logic                                   word_we_i,
  input  logic [WORD_SEL_WIDTH-1:0]              word_sel_i,
  input  logic [31:0]                            word_data_i,
  input  logic                                   set_dirty_i,
  input  logic                                   fill_done_i,
  input  logic [TAG_WIDTH-1:0]                   fill_tag_i
);

  localparam int LINE_WORDS = 1 << WORD_SEL_WIDTH;
  localparam int NUM_LINES  = 1 << INDEX_WIDTH;

  logic [NUM_LINES-1:0]              valid_q;
  logic [NUM_LINES-1:0]              dirty_q;
  logic [TAG_WIDTH-1:0]              tag_q  [NUM_LINES];
  logic [LINE_WORDS-1:0][31:0]       data_q [NUM_LINES];

  assign valid_o = valid_q[index_i];
  assign dirty_o = dirty_q[index_i];
  assign tag_o   = tag_q[index_i];
  assign line_o  = data_q[index_i];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (set_dirty_i) begin
        dirty_q[index_i] <= 1'b1;
      end
      if (fill_done_i) begin
        valid_q[index_i] <= 1'b1;
        dirty_q[index_i] <= 1'b0;
      end
    end
  end

  // Payload storage needs no reset: valid gates every use of it.
  always_ff @(posedge clk) begin
    if (!rst && word_we_i) begin
      data_q[index_i][word_sel_i] <= word_data_i;
    end
    if (!rst && fill_done_i) begin
      tag_q[index_i] <= fill_tag_i;
    end
  end

endmodule

// File: rtl/data_cache.sv
// rtl/data_cache.sv - direct-mapped write-back write-allocate data cache (miss FSM and memory port)
// Define DCACHE_STAT_EN to add the stat_hits/stat_misses counters.
module data_cache import data_cache_pkg::*; #(
  parameter int WORD_SEL_WIDTH = DEF_WORD_SEL_WIDTH,
  parameter int INDEX_WIDTH    = DEF_INDEX_WIDTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_ren,
  input  logic        cpu_wen,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_din,
  output logic [31:0] cpu_dout,
  output logic        cpu_stall,
  output logic        mem_ren,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_dout,
  input  logic [31:0] mem_din,
  input  logic        mem_ack
`ifdef DCACHE_STAT_EN
  ,
  output logic [31:0] stat_hits,
  output logic [31:0] stat_misses
`endif
);

  localparam int TAG_WIDTH  = 32 - 2 - WORD_SEL_WIDTH - INDEX_WIDTH;
  localparam int LINE_WORDS = 1 << WORD_SEL_WIDTH;

  logic [TAG_WIDTH-1:0]      req_tag;
  logic [INDEX_WIDTH-1:0]    req_index;
  logic [WORD_SEL_WIDTH-1:0] req_word;
  logic                      unused_addr_bits;

  assign req_tag          = cpu_addr[31 -: TAG_WIDTH];
  assign req_index        = cpu_addr[WORD_SEL_WIDTH+2 +: INDEX_WIDTH];
  assign req_word         = cpu_addr[2 +: WORD_SEL_WIDTH];
  assign unused_addr_bits = ^cpu_addr[1:0];

  logic                        arr_valid, arr_dirty;
  logic [TAG_WIDTH-1:0]        arr_tag;
  logic [LINE_WORDS-1:0][31:0] arr_line;
  logic                        word_we, set_dirty, fill_done;
  logic [WORD_SEL_WIDTH-1:0]   word_sel;
  logic [31:0]                 word_data;

  data_cache_array #(
    .WORD_SEL_WIDTH (WORD_SEL_WIDTH),
    .INDEX_WIDTH    (INDEX_WIDTH),
    .TAG_WIDTH      (TAG_WIDTH)
  ) u_array (
    .clk         (clk),
    .rst         (rst),
    .index_i     (req_index),
    .valid_o     (arr_valid),
    .dirty_o     (arr_dirty),
    .tag_o       (arr_tag),
    .line_o      (arr_line),
    .word_we_i   (word_we),
    .word_sel_i  (word_sel),
    .word_data_i (word_data),
    .set_dirty_i (set_dirty),
    .fill_done_i (fill_done),
    .fill_tag_i  (req_tag)
  );

  state_e                    state_q, state_d;
  logic [WORD_SEL_WIDTH-1:0] cnt_q, cnt_d;
  logic                      mem_ren_q, mem_ren_d, mem_wen_q, mem_wen_d;
  logic [31:0]               mem_addr_q, mem_addr_d, mem_dout_q, mem_dout_d;
  logic                      hit, req, stall, last_word;

  assign hit       = arr_valid && (arr_tag == req_tag);
  assign req       = cpu_ren || cpu_wen;
  assign last_word = &cnt_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall     = 1'b0;
    word_we   = 1'b0;
    word_sel  = req_word;
    word_data = cpu_din;
    set_dirty = 1'b0;
    fill_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req && !hit) begin
          stall   = 1'b1;
          cnt_d   = '0;
          state_d = arr_dirty ? ST_WB : ST_REFILL;
        end else if (cpu_wen && hit) begin
          word_we   = 1'b1;
          set_dirty = 1'b1;
        end
      end
      ST_WB: begin
        stall = 1'b1;
        if (mem_ack) begin
          cnt_d = cnt_q + 1'b1;
          if (last_word) state_d = ST_REFILL;
        end
      end
      ST_REFILL: begin
        stall = 1'b1;
        if (mem_ack) begin
          word_we   = 1'b1;
          word_sel  = cnt_q;
          word_data = mem_din;
          cnt_d     = cnt_q + 1'b1;
          if (last_word) begin
            fill_done = 1'b1;
            state_d   = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Memory requests are registered from the next state so each ack retires exactly one word.
  always_comb begin
    mem_ren_d  = (state_d == ST_REFILL);
    mem_wen_d  = (state_d == ST_WB);
    mem_addr_d = '0;
    mem_dout_d = '0;
    if (state_d == ST_REFILL) begin
      mem_addr_d = {req_tag, req_index, cnt_d, 2'b00};
    end else if (state_d == ST_WB) begin
      mem_addr_d = {arr_tag, req_index, cnt_d, 2'b00};
      mem_dout_d = arr_line[cnt_d];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      mem_ren_q  <= 1'b0;
      mem_wen_q  <= 1'b0;
      mem_addr_q <= '0;
      mem_dout_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mem_ren_q  <= mem_ren_d;
      mem_wen_q  <= mem_wen_d;
      mem_addr_q <= mem_addr_d;
      mem_dout_q <= mem_dout_d;
    end
  end

  assign cpu_stall = stall && !rst;
  assign cpu_dout  = (!rst && state_q == ST_IDLE && hit) ? arr_line[req_word] : '0;
  assign mem_ren   = mem_ren_q;
  assign mem_wen   = mem_wen_q;
  assign mem_addr  = mem_addr_q;
  assign mem_dout  = mem_dout_q;

`ifdef DCACHE_STAT_EN
  logic        post_refill_q;
  logic [31:0] stat_hits_q, stat_misses_q;

  // The hit that completes a refilled request belongs to that miss, not to the hit count.
  always_ff @(posedge clk) begin
    if (rst) begin
      post_refill_q <= 1'b0;
      stat_hits_q   <= '0;
      stat_misses_q <= '0;
    end else begin
      post_refill_q <= (state_q == ST_REFILL) && (state_d == ST_IDLE);
      if (state_q == ST_IDLE && req && hit && !post_refill_q) begin
        stat_hits_q <= stat_hits_q + 32'd1;
      end
      if (state_q == ST_IDLE && state_d != ST_IDLE) begin
        stat_misses_q <= stat_misses_q + 32'd1;
      end
    end
  end

  assign stat_hits   = stat_hits_q;
  assign stat_misses = stat_misses_q;
`endif

endmodule

// File: tb/tb_data_cache.sv
// tb/tb_data_cache.sv - directed and randomized self-checking bench for data_cache
// Stat counter checks are compiled in when DCACHE_STAT_EN is defined.
module tb_data_cache;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_ren = 1'b0, cpu_wen = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_din = '0;
  logic [31:0] cpu_dout;
  logic        cpu_stall, mem_ren, mem_wen;
  logic [31:0] mem_addr, mem_dout;
  logic [31:0] mem_din = '0;
  logic        mem_ack = 1'b0;
`ifdef DCACHE_STAT_EN
  logic [31:0] stat_hits, stat_misses;
`endif

  always #5 clk = ~clk;

  data_cache dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_ren   (cpu_ren),
    .cpu_wen   (cpu_wen),
    .cpu_addr  (cpu_addr),
    .cpu_din   (cpu_din),
    .cpu_dout  (cpu_dout),
    .cpu_stall (cpu_stall),
    .mem_ren   (mem_ren),
    .mem_wen   (mem_wen),
    .mem_addr  (mem_addr),
    .mem_dout  (mem_dout),
    .mem_din   (mem_din),
    .mem_ack   (mem_ack)
`ifdef DCACHE_STAT_EN
    ,
    .stat_hits   (stat_hits),
    .stat_misses (stat_misses)
`endif
  );

  int checks = 0;
  int failures = 0;

  logic [31:0] ram     [0:1023];
  logic [31:0] ref_mem [0:1023];
  logic [31:0] init_mem[0:1023];

  typedef struct packed {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
  } xfer_t;
  xfer_t xq[$];

  int ack_delay_max = 0;
  int wait_cnt = 0;

  // Memory model: one-cycle ack after a random wait, logs every completed transfer.
  always @(negedge clk) begin
    if (mem_ack) begin
      mem_ack = 1'b0;
    end else if (mem_ren || mem_wen) begin
      if (wait_cnt > 0) begin
        wait_cnt--;
      end else begin
        mem_ack = 1'b1;
        if (mem_wen) begin
          ram[mem_addr[11:2]] = mem_dout;
          xq.push_back({1'b1, mem_addr, mem_dout});
        end else begin
          mem_din = ram[mem_addr[11:2]];
          xq.push_back({1'b0, mem_addr, mem_din});
        end
        wait_cnt = $urandom_range(ack_delay_max, 0);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One core access starting at a negedge; returns after the committing posedge.
  task automatic access(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                        output logic [31:0] dout, output bit first_stall, output int nxfer);
    int cyc;
    xq.delete();
    cpu_ren  = !wr;
    cpu_wen  = wr;
    cpu_addr = addr;
    cpu_din  = data;
    #1;
    first_stall = cpu_stall;
    cyc = 0;
    while (cpu_stall && cyc < 300) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    chk("stall_release", cpu_stall, 1'b0);
    dout = cpu_dout;
    @(negedge clk);
    cpu_ren = 1'b0;
    cpu_wen = 1'b0;
    nxfer = xq.size();
  endtask

  bit               m_valid[16];
  bit               m_dirty[16];
  logic [23:0]      m_tag[16];
  int               m_hits = 0, m_misses = 0;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0;
      m_dirty[i] = 0;
    end
    for (int i = 0; i < 1024; i++) ref_mem[i] = ram[i];
    m_hits = 0;
    m_misses = 0;
  endtask

  // Cache is architecturally transparent: loads see the latest store; misses cost 4 or 8 transfers.
  task automatic checked_access(input bit wr, input logic [31:0] addr, input logic [31:0] data);
    logic [3:0]  idx;
    logic [23:0] tag;
    logic [31:0] dout;
    bit          hit, fs;
    int          nx, exp_x, nrd;
    idx   = addr[7:4];
    tag   = addr[31:8];
    hit   = m_valid[idx] && (m_tag[idx] == tag);
    exp_x = hit ? 0 : (m_dirty[idx] ? 8 : 4);
    access(wr, addr, data, dout, fs, nx);
    chk("stall_on_entry", fs, !hit);
    chk("xfer_count", nx, exp_x);
    nrd = 0;
    foreach (xq[i]) begin
      if (xq[i].w) begin
        chk("wb_data", xq[i].d, ref_mem[xq[i].a[11:2]]);
      end else begin
        chk("refill_addr", xq[i].a, {addr[31:4], 4'(nrd * 4)});
        nrd++;
      end
    end
    if (hit) m_hits++;
    else begin
      m_misses++;
      m_valid[idx] = 1;
      m_tag[idx]   = tag;
      m_dirty[idx] = 0;
    end
    if (wr) begin
      ref_mem[addr[11:2]] = data;
      m_dirty[idx] = 1;
    end else begin
      chk("load_data", dout, ref_mem[addr[11:2]]);
    end
  endtask

  initial begin
    logic [31:0] dout;
    bit          fs;
    int          nx, cyc;
    logic [31:0] a, d;
    bit          wr;

    for (int i = 0; i < 1024; i++) init_mem[i] = (i * 32'h9E3779B1) ^ 32'h5A5A0000;
    init_mem[16] = 32'hA5A5A5A5;
    for (int i = 0; i < 1024; i++) ram[i] = init_mem[i];

    repeat (3) @(negedge clk);
    #1;
    chk("rst_stall", cpu_stall, 1'b0);
    chk("rst_dout", cpu_dout, 32'h0);
    chk("rst_mem_ren", mem_ren, 1'b0);
    chk("rst_mem_wen", mem_wen, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_dout", mem_dout, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Cold load miss: four refill reads from word 0.
    access(0, 32'h40, 0, dout, fs, nx);
    chk("t1_stall", fs, 1'b1);
    chk("t1_xfers", nx, 4);
    for (int i = 0; i < 4 && i < xq.size(); i++) begin
      chk("t1_rd", xq[i].w, 1'b0);
      chk("t1_addr", xq[i].a, 32'h40 + 32'(i * 4));
    end
    chk("t1_dout", dout, 32'hA5A5A5A5);

    access(0, 32'h44, 0, dout, fs, nx);
    chk("t2_stall", fs, 1'b0);
    chk("t2_xfers", nx, 0);
    chk("t2_dout", dout, init_mem[17]);

    access(1, 32'h48, 32'h12345678, dout, fs, nx);
    chk("t3_st_stall", fs, 1'b0);
    chk("t3_st_xfers", nx, 0);
    access(0, 32'h48, 0, dout, fs, nx);
    chk("t3_ld_stall", fs, 1'b0);
    chk("t3_ld_xfers", nx, 0);
    chk("t3_dout", dout, 32'h12345678);

    // Conflict miss on a dirty line: write-back of 0x40 line, then refill of 0x140.
    access(0, 32'h148, 0, dout, fs, nx);
    chk("t4_stall", fs, 1'b1);
    chk("t4_xfers", nx, 8);
    for (int i = 0; i < 8 && i < xq.size(); i++) begin
      chk("t4_dir", xq[i].w, (i < 4));
      chk("t4_addr", xq[i].a, (i < 4) ? 32'h40 + 32'(i * 4) : 32'h140 + 32'((i - 4) * 4));
      if (i < 4) chk("t4_wb_data", xq[i].d, (i == 2) ? 32'h12345678 : init_mem[16 + i]);
    end
    chk("t4_dout", dout, init_mem[32'h148 >> 2]);
`ifdef DCACHE_STAT_EN
    chk("stat_hits", stat_hits, 32'd3);
    chk("stat_misses", stat_misses, 32'd2);
`endif

    // Reset in the middle of a refill, after two words have landed.
    xq.delete();
    cpu_ren  = 1'b1;
    cpu_addr = 32'h80;
    cyc = 0;
    while (xq.size() < 2 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("t5_acks", xq.size(), 2);
    @(negedge clk);
    rst = 1'b1;
    cpu_ren = 1'b0;
    @(negedge clk);
    #1;
    chk("t5_mem_ren", mem_ren, 1'b0);
    chk("t5_stall", cpu_stall, 1'b0);
    chk("t5_mem_addr", mem_addr, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    checked_access(0, 32'h140, 0);
    chk("t5_reload_miss", m_misses, 1);

    ack_delay_max = 3;
    for (int n = 0; n < 400; n++) begin
      wr = 1'($urandom_range(1, 0));
      a  = $urandom & 32'h3FC;
      d  = $urandom;
      checked_access(wr, a, d);
    end
    // Re-read a spread of addresses so evicted dirty data is observed through memory.
    for (int i = 0; i < 64; i++) begin
      checked_access(0, 32'(i * 16 + 4 * (i % 4)), 0);
    end
`ifdef DCACHE_STAT_EN
    chk("rand_stat_hits", stat_hits, 32'(m_hits));
    chk("rand_stat_misses", stat_misses, 32'(m_misses));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
